// File: rtl/spo_eval_arbiter_pkg.sv
// Shared types, widths and helpers for the round-robin evaluator arbiter.
package spo_eval_arbiter_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;
    // Raw input vector width (S1), carried level width (S2/S3), result width
    localparam int unsigned IN_W  = 7;
    localparam int unsigned MID_W = 5;
    localparam int unsigned OUT_W = 4;

    // Payload between levels: two computed gates plus the buffered skip-level inputs
    typedef struct packed {
        logic ga;
        logic gb;
        logic i0;
        logic i3;
        logic i6;
    } mid_t;

    // S1 record holds the raw request vector
    typedef struct packed {
        logic            valid;
        logic [IDW-1:0]  id;
        logic [IN_W-1:0] payload;
    } s1_rec_t;

    // S2/S3 record holds the level results
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        mid_t           payload;
    } mid_rec_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spo_eval_arbiter_if.sv
// Request/response bundle between requesters/consumer (master) and the arbiter (slave).
interface spo_eval_arbiter_if;
    import spo_eval_arbiter_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [OUT_W-1:0]     rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_ready;
    logic                 busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/spo_eval_pipe.sv
// Three-stage path-balanced evaluator. S1 holds the raw vector, S2 the level-1
// gates, S3 the level-2 gates; the level-3 outputs are decoded from S3.
module spo_eval_pipe
    import spo_eval_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  s1_rec_t          s1_load,
    output logic             s3_valid,
    output logic [OUT_W-1:0] rsp_data,
    output logic [IDW-1:0]   rsp_id,
    output logic             busy
);

    s1_rec_t  s1_q;
    mid_rec_t s2_q;
    mid_rec_t s3_q;
    mid_t     s2_d;
    mid_t     s3_d;

    // Level 1: g0 = i1&i2, g1 = i4&i5; skip-level inputs are buffered
    always_comb begin
        s2_d    = '0;
        s2_d.ga = s1_q.payload[1] & s1_q.payload[2];
        s2_d.gb = s1_q.payload[4] & s1_q.payload[5];
        s2_d.i0 = s1_q.payload[0];
        s2_d.i3 = s1_q.payload[3];
        s2_d.i6 = s1_q.payload[6];
    end

    // Level 2: g2 = ~g0, g3 = i3&g1
    always_comb begin
        s3_d    = '0;
        s3_d.ga = ~s2_q.payload.ga;
        s3_d.gb = s2_q.payload.i3 & s2_q.payload.gb;
        s3_d.i0 = s2_q.payload.i0;
        s3_d.i3 = s2_q.payload.i3;
        s3_d.i6 = s2_q.payload.i6;
    end

    // Stage registers; everything freezes while adv is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (adv) begin
            s1_q         <= s1_load;
            s2_q.valid   <= s1_q.valid;
            s2_q.id      <= s1_q.id;
            s2_q.payload <= s2_d;
            s3_q.valid   <= s2_q.valid;
            s3_q.id      <= s2_q.id;
            s3_q.payload <= s3_d;
        end
    end

    // Level 3: outputs decoded from S3 so they hold stable with S3
    always_comb begin
        rsp_data    = '0;
        rsp_data[0] = maj3(s3_q.payload.i0, s3_q.payload.i3, s3_q.payload.ga);
        rsp_data[1] = s3_q.payload.i3 & s3_q.payload.ga;
        rsp_data[2] = s3_q.payload.i3 & s3_q.payload.gb;
        rsp_data[3] = maj3(s3_q.payload.i3, s3_q.payload.gb, s3_q.payload.i6);
    end

    assign s3_valid = s3_q.valid;
    assign rsp_id   = s3_q.id;
    assign busy     = s1_q.valid | s2_q.valid | s3_q.valid;

endmodule

// File: rtl/spo_eval_arbiter.sv
// Round-robin arbiter feeding a shared pipelined evaluator. Only NREQ = 4 /
// IDW = 2 is supported: the pointer relies on power-of-two wrap-around.
module spo_eval_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spo_eval_arbiter_if.slave  bus
);

    import spo_eval_arbiter_pkg::s1_rec_t;
    import spo_eval_arbiter_pkg::IN_W;

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic           adv;
    logic           xfer;
    logic           s3_valid;
    s1_rec_t        s1_load;

    assign adv = ~s3_valid | bus.rsp_ready;
    // rst_n gates the accept so req_ready stays low while reset is held
    assign xfer = rst_n & adv & gnt_found;

    // Search ptr, ptr+1, ... with wrap; first valid requester wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[ptr_q + IDW'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ptr_q + IDW'(k);
            end
        end
    end

    // One-hot accept for the granted requester only
    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // S1 load record; a bubble is loaded when nothing transfers
    always_comb begin
        s1_load         = '0;
        s1_load.valid   = xfer;
        s1_load.id      = gnt_idx;
        s1_load.payload = bus.req_data[int'(gnt_idx) * IN_W +: IN_W];
    end

    // Pointer moves past the winner so it cannot win again while others wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= gnt_idx + IDW'(1);
        end
    end

    spo_eval_pipe u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .s1_load  (s1_load),
        .s3_valid (s3_valid),
        .rsp_data (bus.rsp_data),
        .rsp_id   (bus.rsp_id),
        .busy     (bus.busy)
    );

    assign bus.rsp_valid = s3_valid;

endmodule

// File: tb/tb_spo_eval_arbiter.sv
// Directed bench for spo_eval_arbiter: reset, latency, ordering, round-robin,
// backpressure and mid-flight reset, with hand-computed expected results.
module tb_spo_eval_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Vectors and their hand-evaluated results {o3,o2,o1,o0}
    logic [6:0] vec     [4] = '{7'h08, 7'h7F, 7'h00, 7'h38};
    logic [3:0] exp_rsp [4] = '{4'b0011, 4'b1101, 4'b0000, 4'b1111};
    int         grants  [6] = '{3, 0, 1, 2, 3, 0};

    spo_eval_arbiter_if bus ();

    spo_eval_arbiter #(
        .NREQ (4),
        .IDW  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [6:0] d);
        bus.req_data[r*7 +: 7] = d;
    endtask

    task automatic check_rsp(input string tag, input logic v, input int id, input logic [3:0] d);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
        if (v) begin
            check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
            check({tag, "_data"}, 32'(bus.rsp_data), 32'(d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] onehot;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // Reset outputs, including with all requesters asking
        #12;
        bus.req_valid = 4'hF;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        bus.req_valid = '0;
        step();
        rst_n = 1'b1;
        #1;

        // Single request from requester 0, two-edge latency
        set_req(0, 7'b0001000);
        bus.req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        check("single_busy", 32'(bus.busy), 32'h1);
        check_rsp("single_e0", 1'b0, 0, 4'h0);
        step();
        check_rsp("single_e1", 1'b0, 0, 4'h0);
        step();
        check_rsp("single_e2", 1'b1, 0, 4'b0011);
        step();
        check_rsp("single_e3", 1'b0, 0, 4'h0);
        check("single_idle", 32'(bus.busy), 32'h0);

        // Back-to-back vectors from requester 1 arrive in order
        set_req(1, 7'h7F);
        bus.req_valid = 4'b0010;
        step();
        set_req(1, 7'h00);
        step();
        bus.req_valid = '0;
        step();
        check_rsp("seq_first", 1'b1, 1, 4'b1101);
        step();
        check_rsp("seq_second", 1'b1, 1, 4'b0000);
        step();
        check_rsp("seq_end", 1'b0, 0, 4'h0);

        // Round-robin: a lone req3 returns ptr to 0, then all four contend
        for (int r = 0; r < 4; r++) set_req(r, vec[r]);
        for (int k = 0; k < 9; k++) begin
            if (k == 0) bus.req_valid = 4'b1000;
            else if (k <= 5) bus.req_valid = 4'b1111;
            else bus.req_valid = 4'b0000;
            #1;
            if (k <= 5) begin
                onehot = 4'b0001 << grants[k];
                check($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(onehot));
            end
            step();
            if (k >= 2 && k <= 7) begin
                check_rsp($sformatf("rr_rsp_%0d", k), 1'b1, grants[k-2], exp_rsp[grants[k-2]]);
            end else begin
                check_rsp($sformatf("rr_rsp_%0d", k), 1'b0, 0, 4'h0);
            end
        end

        // Backpressure with grants 1,2,3 in flight
        bus.req_valid = 4'b1111;
        for (int b = 0; b < 3; b++) step();
        bus.rsp_ready = 1'b0;
        #1;
        check_rsp("bp_start", 1'b1, 1, exp_rsp[1]);
        for (int s = 0; s < 5; s++) begin
            step();
            check_rsp($sformatf("bp_hold_%0d", s), 1'b1, 1, exp_rsp[1]);
            check($sformatf("bp_ready_%0d", s), 32'(bus.req_ready), 32'h0);
            check($sformatf("bp_busy_%0d", s), 32'(bus.busy), 32'h1);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        #1;
        check_rsp("bp_rel0", 1'b1, 1, exp_rsp[1]);
        step();
        check_rsp("bp_rel1", 1'b1, 2, exp_rsp[2]);
        step();
        check_rsp("bp_rel2", 1'b1, 3, exp_rsp[3]);
        step();
        check_rsp("bp_rel3", 1'b0, 0, 4'h0);

        // Reset with two entries in flight, one already presented
        bus.req_valid = 4'b0011;
        step();
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        step();
        check_rsp("mr_before", 1'b1, 0, exp_rsp[0]);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mr_busy", 32'(bus.busy), 32'h0);
        check("mr_rsp_data", 32'(bus.rsp_data), 32'h0);
        bus.req_valid = 4'b0110;
        #1;
        check("mr_ready_in_rst", 32'(bus.req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        check("mr_first_grant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        check_rsp("mr_e0", 1'b0, 0, 4'h0);
        step();
        check_rsp("mr_e1", 1'b0, 0, 4'h0);
        step();
        check_rsp("mr_e2", 1'b1, 1, exp_rsp[1]);
        step();
        check_rsp("mr_e3", 1'b0, 0, 4'h0);
        check("mr_idle", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spo_eval_arbiter.md
SPO_EVAL_ARBITER -- requirements
Module: spo_eval_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the evaluator; only the value 4 is supported.
REQ-002 Parameter: IDW, 2, requester-ID width, equal to log2(NREQ).
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  NREQ  per-requester request valid.
REQ-006 Port: req_data  in  NREQ*7  per-requester input vector; slice i is bits [7i+6:7i]; bit k of a slice is input ik.
REQ-007 Port: req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 Port: rsp_valid  out  1  result valid.
REQ-009 Port: rsp_data  out  4  result {o3,o2,o1,o0}.
REQ-010 Port: rsp_id  out  IDW  index of the requester that owns the result.
REQ-011 Port: rsp_ready  in  1  consumer accept.
REQ-012 Port: busy  out  1  high while any pipeline stage holds a valid entry.

Function
REQ-013 The evaluator function SHALL be defined in terms of these intermediate signals:
- g0 = i1&i2, g1 = i4&i5 (level 1);
- g2 = ~g0, g3 = i3&g1 (level 2).
REQ-014 The evaluator outputs SHALL be (level 3):
- o0 = MAJ(i0,i3,g2), o1 = i3&g2;
- o2 = i3&g3, o3 = MAJ(i3,g3,i6).
REQ-015 The evaluator SHALL be path-balanced with one register stage per logic level (S1, S2, S3); every signal that skips a level, such as i3, i0 and i6, SHALL be carried through a buffer register.
REQ-016 Each stage SHALL carry a valid bit and the requester ID alongside its data.
REQ-017 The pipeline advance condition SHALL be adv = !S3.valid | rsp_ready; when adv=0, all stages hold their contents.
REQ-018 The arbiter SHALL be round-robin with pointer ptr (0..NREQ-1): grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ... with wrap-around mod NREQ.
REQ-019 req_ready[g] = adv & req_valid[g] for the granted index g; all other bits SHALL be 0.
REQ-020 A transfer is req_valid[g] & req_ready[g]; on a transfer, S1 loads {1, g, data} and ptr becomes (g+1) mod NREQ.
REQ-021 If there is no transfer while adv=1, S1.valid SHALL load 0; ptr is unchanged.
REQ-022 Latency: a request accepted on edge E SHALL present rsp_valid=1 after edge E+2 when adv stays 1.
REQ-023 Throughput SHALL be one request per cycle at sustained rsp_ready=1.
REQ-024 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id SHALL hold stable, and all req_ready bits SHALL be 0.
REQ-025 A requester SHALL NOT be granted twice in a row while any other requester is valid.
REQ-026 busy = S1.valid | S2.valid | S3.valid.

Reset
REQ-027 On rst_n low, asynchronously:
- all stage valid bits, stage data and ID fields are cleared;
- ptr is set to 0.
REQ-028 Outputs during reset: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight entries without emitting them.
REQ-030 The first grant after reset release SHALL start its search at requester 0.

Structure
REQ-031 A shared package SHALL hold:
- NREQ, IDW and the stage width constants;
- a stage-record typedef {valid, id, payload};
- the MAJ3 function.
REQ-032 Arbitration and flow control stay in spo_eval_arbiter.
REQ-033 The evaluator SHALL be one sub-module, spo_eval_pipe, taking adv and the S1 load as inputs.

Verification
REQ-034 Single request: only req0, data 7'b0001000 -> accepted on edge E; rsp_valid after E+2 with rsp_data=4'b0011, rsp_id=0.
REQ-035 Input vectors, one per cycle at rsp_ready=1: 7'h7F -> 4'b1101, then 7'h00 -> 4'b0000; results arrive in order on consecutive cycles.
REQ-036 All four requesters valid continuously, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows the same sequence.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles with 3 entries in flight -> rsp_data/rsp_id stable, req_ready=0, busy=1; release -> 3 results in order, no loss or duplication.
REQ-038 Reset mid-flight: assert rst_n=0 with 2 entries in flight -> rsp_valid=0 and busy=0 immediately; after release, the first grant goes to the lowest valid index ≥ 0.
